// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back path.
package wb_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int WB_WORD_SIZE = 16;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [WB_WORD_SIZE-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending load write-backs; pointers wrap naturally (power-of-two depth).
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_req_t                din,
  output wb_req_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results into one registered register-file write per cycle.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int WORD_SIZE  = WB_WORD_SIZE,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [REG_ADDR_W-1:0]       alu_rd,
  input  logic [WORD_SIZE-1:0]        alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [REG_ADDR_W-1:0]       mem_rd,
  input  logic [WORD_SIZE-1:0]        mem_data,
  output logic                        wb_en,
  output logic [REG_ADDR_W-1:0]       wb_rd,
  output logic [WORD_SIZE-1:0]        wb_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        idle
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_ONE = 1;

  wb_req_t       fifo_din;
  wb_req_t       fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          starve;
  logic          alu_fire;
  logic [WW-1:0] wait_cnt;

  assign mem_ready = !fifo_full;
  assign starve    = !fifo_empty && (wait_cnt == WAIT_MAX);
  assign alu_ready = !starve;
  assign idle      = fifo_empty && !wb_en;

  // x0 transfers are accepted but never claim the write slot or a FIFO entry.
  assign alu_fire = alu_valid && alu_ready && (alu_rd != ZERO_REG);
  assign pop      = !alu_fire && !fifo_empty;
  assign push     = mem_valid && mem_ready && (mem_rd != ZERO_REG);
  assign fifo_din = '{rd: mem_rd, data: mem_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wait_cnt <= '0;
    end else begin
      wb_en <= alu_fire || pop;
      if (alu_fire) begin
        wb_rd   <= alu_rd;
        wb_data <= alu_data;
      end else if (pop) begin
        wb_rd   <= fifo_head.rd;
        wb_data <= fifo_head.data;
      end
      if (fifo_empty || pop)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WAIT_ONE;
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table plus fill, wrap and reset sequences.
module tb_writeback_unit;
  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [15:0] mem_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [15:0] wb_data;
  logic [2:0]  fifo_count;
  logic        idle;

  int checks;
  int failures;

  writeback_unit #(.WORD_SIZE(16), .FIFO_DEPTH(4), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fifo_count(fifo_count), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [15:0] adata,
                       input logic mv, input logic [4:0] mrd, input logic [15:0] mdata);
    alu_valid = av; alu_rd = ard; alu_data = adata;
    mem_valid = mv; mem_rd = mrd; mem_data = mdata;
  endtask

  typedef struct packed {
    logic        av;
    logic [4:0]  ard;
    logic [15:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [15:0] mdata;
    logic        en;
    logic [4:0]  rd;
    logic [15:0] data;
    logic [2:0]  cnt;
    logic        ar;
    logic        mr;
    logic        idl;
  } vec_t;

  vec_t vecs[14];

  // wrap-test reference model
  logic [20:0] mq[$];
  int          mwait;
  logic        m_en;
  logic [4:0]  m_rd;
  logic [15:0] m_data;

  initial begin
    int ld;
    int next_ld;
    logic [4:0] seen[$];
    logic starve_m, afire_m, pop_m, push_m;
    logic [20:0] head;

    checks = 0;
    failures = 0;

    // inputs | expected state seen during that cycle (before its clock edge)
    vecs[0]  = '{1'b1, 5'd5, 16'h1234, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd5, 16'h1234, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd7, 16'hBEEF, 1'b0, 5'd5, 16'h1234, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd5, 16'h1234, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd7, 16'hBEEF, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd0, 16'hAAAA, 1'b1, 5'd0, 16'h5555, 1'b0, 5'd7, 16'hBEEF, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd7, 16'hBEEF, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd3, 16'h0033, 1'b0, 5'd7, 16'hBEEF, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 5'd0, 16'h1111, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd7, 16'hBEEF, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd3, 16'h0033, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 5'd4, 16'h4444, 1'b1, 5'd6, 16'h0066, 1'b0, 5'd3, 16'h0033, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd4, 16'h4444, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b1, 5'd6, 16'h0066, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000, 1'b0, 5'd6, 16'h0066, 3'd0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].mv, vecs[i].mrd, vecs[i].mdata);
      #1;
      chk($sformatf("v%0d_wb_en", i), 32'(wb_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].data));
      chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ar));
      chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].mr));
      chk($sformatf("v%0d_idle", i), 32'(idle), 32'(vecs[i].idl));
    end

    // Fill and backpressure with ALU held busy on rd 9.
    ld = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      drive(c < 20, 5'd9, 16'h9999, ld <= 5, 5'(ld), 16'h1000 + 16'(ld));
      #1;
      if (wb_en && wb_rd != 5'd9) seen.push_back(wb_rd);
      if (c == 3) begin
        chk("fill_c3_count", 32'(fifo_count), 32'd3);
        chk("fill_c3_mem_ready", 32'(mem_ready), 32'd1);
        chk("fill_c3_alu_ready", 32'(alu_ready), 32'd1);
      end
      if (c == 4) begin
        chk("fill_c4_count", 32'(fifo_count), 32'd4);
        chk("fill_c4_mem_ready", 32'(mem_ready), 32'd0);
        chk("fill_c4_alu_ready", 32'(alu_ready), 32'd0);
      end
      if (c == 5) begin
        chk("fill_c5_wb_en", 32'(wb_en), 32'd1);
        chk("fill_c5_wb_rd", 32'(wb_rd), 32'd1);
        chk("fill_c5_wb_data", 32'(wb_data), 32'h1001);
        chk("fill_c5_alu_ready", 32'(alu_ready), 32'd1);
        chk("fill_c5_mem_ready", 32'(mem_ready), 32'd1);
      end
      if (c == 6) chk("fill_c6_mem_ready", 32'(mem_ready), 32'd0);
      if (mem_valid && mem_ready) ld++;
    end
    chk("fill_idle_end", 32'(idle), 32'd1);
    chk("fill_load_count", 32'(seen.size()), 32'd5);
    for (int k = 0; k < seen.size() && k < 5; k++)
      chk($sformatf("fill_order_%0d", k), 32'(seen[k]), 32'(k + 1));

    // Wrap test: 12 loads against a cycle model, ALU busy two cycles in three.
    mq.delete();
    mwait = 0;
    m_en = 1'b0;
    m_rd = '0;
    m_data = '0;
    ld = 0;
    next_ld = 10;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      drive((c < 30) && (c % 3 != 0), 5'd30, 16'h3000 + 16'(c), ld < 12, 5'(10 + ld), 16'hA000 + 16'(ld));
      #1;
      starve_m = (mq.size() != 0) && (mwait == 3);
      chk($sformatf("wrap%0d_count", c), 32'(fifo_count), 32'(mq.size()));
      chk($sformatf("wrap%0d_mem_ready", c), 32'(mem_ready), 32'(mq.size() != 4));
      chk($sformatf("wrap%0d_alu_ready", c), 32'(alu_ready), 32'(!starve_m));
      chk($sformatf("wrap%0d_wb_en", c), 32'(wb_en), 32'(m_en));
      if (m_en) begin
        chk($sformatf("wrap%0d_wb_rd", c), 32'(wb_rd), 32'(m_rd));
        chk($sformatf("wrap%0d_wb_data", c), 32'(wb_data), 32'(m_data));
      end
      if (wb_en && wb_rd != 5'd30) begin
        chk($sformatf("wrap%0d_order", c), 32'(wb_rd), 32'(next_ld));
        next_ld++;
      end
      afire_m = alu_valid && !starve_m && (alu_rd != 5'd0);
      pop_m   = !afire_m && (mq.size() != 0);
      push_m  = mem_valid && (mq.size() != 4) && (mem_rd != 5'd0);
      m_en = afire_m || pop_m;
      if (afire_m) begin
        m_rd = alu_rd;
        m_data = alu_data;
      end
      if (mq.size() == 0 || pop_m) mwait = 0;
      else if (mwait != 3) mwait++;
      if (pop_m) begin
        head = mq.pop_front();
        if (!afire_m) {m_rd, m_data} = head;
      end
      if (push_m) begin
        mq.push_back({mem_rd, mem_data});
        ld++;
      end
    end
    chk("wrap_total_loads", 32'(next_ld), 32'd22);

    // Reset with three queued loads and a write in flight.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd9, 16'h9090, 1'b1, 5'(c + 1), 16'h0111 * 16'(c + 1));
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
    #1;
    chk("prerst_count", 32'(fifo_count), 32'd3);
    chk("prerst_wb_en", 32'(wb_en), 32'd1);
    chk("prerst_wb_rd", 32'(wb_rd), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst%0d_wb_en", c), 32'(wb_en), 32'd0);
      chk($sformatf("postrst%0d_count", c), 32'(fifo_count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
